div_seq_sgn: RTL and testbench

Parametrised sequential radix-2 restoring divider with start/ready/done_tick handshake. Successor to the 8-bit unsigned divider used in the division test wrapper. Adds a per-operation signed/unsigned mode, a divide-by-zero flag with a short-circuit path, and defined signed-overflow results. Sits between operand sources (switches, register file) and result consumers (hex display mux, LEDs).

---
 rtl/div_seq_sgn.sv | 113 +++++++++++
 tb/tb_div_seq_sgn.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_sgn.sv
// rtl/div_seq_sgn.sv - sequential radix-2 restoring divider, signed/unsigned, divide-by-zero flag
module div_seq_sgn #(
  parameter int W    = 8,
  parameter int CBIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sgn,
  input  logic [W-1:0] dvnd,
  input  logic [W-1:0] dvsr,
  output logic         ready,
  output logic         done_tick,
  output logic         dvz,
  output logic [W-1:0] quo,
  output logic [W-1:0] rmd
);

  typedef enum logic [1:0] {IDLE, OP, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic            sgn_r, dvnd_neg, dvsr_neg;
  logic [W-1:0]    rh, rl, d_mag;
  logic [CBIT-1:0] cnt;

  logic            dvnd_is_neg, dvsr_is_neg;
  logic [W-1:0]    dvnd_mag, dvsr_mag;
  logic [W:0]      rh_shift;
  logic [W-1:0]    rh_sub;
  logic            q_bit;

  always_comb begin
    dvnd_is_neg = sgn & dvnd[W-1];
    dvsr_is_neg = sgn & dvsr[W-1];
    dvnd_mag    = dvnd_is_neg ? -dvnd : dvnd;
    dvsr_mag    = dvsr_is_neg ? -dvsr : dvsr;
    // Compare on W+1 bits; the subtraction result always fits back into W bits.
    rh_shift    = {rh, rl[W-1]};
    q_bit       = (rh_shift >= {1'b0, d_mag});
    rh_sub      = rh_shift[W-1:0] - d_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done_tick = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = (dvsr == '0) ? DONE : OP;
      end
      OP:      if (cnt == CBIT'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE: begin
        done_tick = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sgn_r    <= 1'b0;
      dvnd_neg <= 1'b0;
      dvsr_neg <= 1'b0;
      rh       <= '0;
      rl       <= '0;
      d_mag    <= '0;
      cnt      <= '0;
      dvz      <= 1'b0;
      quo      <= '0;
      rmd      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sgn_r    <= sgn;
          dvnd_neg <= dvnd_is_neg;
          dvsr_neg <= dvsr_is_neg;
          if (dvsr == '0) begin
            quo <= '1;
            rmd <= dvnd;
            dvz <= 1'b1;
          end else begin
            rh    <= '0;
            rl    <= dvnd_mag;
            d_mag <= dvsr_mag;
            cnt   <= CBIT'(W);
            dvz   <= 1'b0;
          end
        end
        OP: begin
          rh  <= q_bit ? rh_sub : rh_shift[W-1:0];
          rl  <= {rl[W-2:0], q_bit};
          cnt <= cnt - CBIT'(1);
        end
        FIX: begin
          // Quotient truncates toward zero; remainder takes the dividend's sign.
          quo <= (sgn_r & (dvnd_neg ^ dvsr_neg)) ? -rl : rl;
          rmd <= dvnd_neg ? -rh : rh;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_sgn.sv
// tb/tb_div_seq_sgn.sv - randomized self-checking bench for div_seq_sgn (W=8 and W=16 instances)
module tb_div_seq_sgn;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic        sgn_i = 1'b0;
  logic        sel16 = 1'b0;
  logic [15:0] dvnd_i = '0;
  logic [15:0] dvsr_i = '0;

  logic        start8, start16;
  logic        ready8, done8, dvz8;
  logic [7:0]  quo8, rmd8;
  logic        ready16, done16, dvz16;
  logic [15:0] quo16, rmd16;

  logic        o_ready, o_done, o_dvz;
  logic [15:0] o_quo, o_rmd;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] prev_q [2];
  logic [15:0] prev_r [2];

  always #5 clk = ~clk;

  assign start8  = start_i & ~sel16;
  assign start16 = start_i & sel16;
  assign o_ready = sel16 ? ready16 : ready8;
  assign o_done  = sel16 ? done16 : done8;
  assign o_dvz   = sel16 ? dvz16 : dvz8;
  assign o_quo   = sel16 ? quo16 : {8'h00, quo8};
  assign o_rmd   = sel16 ? rmd16 : {8'h00, rmd8};

  div_seq_sgn #(.W(8), .CBIT(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sgn(sgn_i),
    .dvnd(dvnd_i[7:0]), .dvsr(dvsr_i[7:0]),
    .ready(ready8), .done_tick(done8), .dvz(dvz8), .quo(quo8), .rmd(rmd8)
  );

  div_seq_sgn #(.W(16), .CBIT(5)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .sgn(sgn_i),
    .dvnd(dvnd_i), .dvsr(dvsr_i),
    .ready(ready16), .done_tick(done16), .dvz(dvz16), .quo(quo16), .rmd(rmd16)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division (SV truncates toward zero, % follows dividend).
  function automatic void ref_div(input int w, input bit s, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] q,
                                  output logic [15:0] r, output bit z);
    longint mask, av, bv;
    mask = (longint'(1) << w) - 1;
    av = longint'(a) & mask;
    bv = longint'(b) & mask;
    if (bv == 0) begin
      q = 16'(mask);
      r = 16'(av);
      z = 1'b1;
      return;
    end
    if (s) begin
      if (av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
      if (bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
    end
    q = 16'((av / bv) & mask);
    r = 16'((av % bv) & mask);
    z = 1'b0;
  endfunction

  task automatic run_op(input int w, input bit s, input logic [15:0] a,
                        input logic [15:0] b, input bit spam);
    logic [15:0] eq, er;
    bit ez, seen, ok_ready, ok_hold;
    int lat, c, idx;
    idx = (w == 16) ? 1 : 0;
    sel16 = (w == 16);
    ref_div(w, s, a, b, eq, er, ez);
    lat = ez ? 1 : w + 2;
    c = 0;
    while (o_ready !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("ready_before_start", o_ready, 1);
    sgn_i = s; dvnd_i = a; dvsr_i = b; start_i = 1'b1;
    seen = 0; ok_ready = 1; ok_hold = 1; c = 0;
    while (!seen && c < 60) begin
      @(negedge clk);
      c++;
      if (o_ready !== 1'b0) ok_ready = 0;
      if (o_done === 1'b1) seen = 1;
      else if (o_quo !== prev_q[idx] || o_rmd !== prev_r[idx]) ok_hold = 0;
      start_i = spam && !seen;
      if (spam) begin
        dvnd_i = 16'($urandom);
        dvsr_i = 16'($urandom) | 16'h1;
      end
    end
    start_i = 1'b0;
    chk("done_seen", seen, 1);
    chk("latency", c, lat);
    chk("quo", o_quo, eq);
    chk("rmd", o_rmd, er);
    chk("dvz", o_dvz, ez);
    chk("ready_low_while_busy", ok_ready, 1);
    if (!ez) chk("outputs_hold_during_op", ok_hold, 1);
    @(negedge clk);
    chk("done_one_cycle", o_done, 0);
    chk("ready_after_done", o_ready, 1);
    chk("quo_held_after_done", o_quo, eq);
    prev_q[idx] = eq;
    prev_r[idx] = er;
  endtask

  task automatic rand_ops(input int w, input int n);
    logic [15:0] a, b, msb, mask;
    bit s;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    msb  = (w == 16) ? 16'h8000 : 16'h0080;
    for (int i = 0; i < n; i++) begin
      s = 1'($urandom);
      a = 16'($urandom) & mask;
      b = 16'($urandom) & mask;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin s = 1'b1; a = msb; b = mask; end
        2: b = 16'($urandom_range(1, 3));
        default: ;
      endcase
      run_op(w, s, a, b, 1'b0);
    end
  endtask

  initial begin
    int c;
    bit no_done;
    for (int i = 0; i < 2; i++) begin
      prev_q[i] = '0;
      prev_r[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready8", ready8, 1);
    chk("rst_done8", done8, 0);
    chk("rst_dvz8", dvz8, 0);
    chk("rst_quo8", quo8, 0);
    chk("rst_rmd8", rmd8, 0);
    chk("rst_ready16", ready16, 1);
    chk("rst_quo16", quo16, 0);

    run_op(8, 1'b0, 16'd200, 16'd7, 1'b0);
    chk("t1_quo_const", o_quo, 16'h1C);
    chk("t1_rmd_const", o_rmd, 16'h04);
    run_op(8, 1'b1, 16'h00F9, 16'h0002, 1'b0);
    chk("t2a_quo_const", o_quo, 16'hFD);
    chk("t2a_rmd_const", o_rmd, 16'hFF);
    run_op(8, 1'b1, 16'h0007, 16'h00FE, 1'b0);
    chk("t2b_quo_const", o_quo, 16'hFD);
    chk("t2b_rmd_const", o_rmd, 16'h01);
    run_op(8, 1'b0, 16'h0055, 16'h0000, 1'b0);
    run_op(8, 1'b1, 16'h0055, 16'h0000, 1'b0);
    chk("t3_dvz_const", o_dvz, 1);
    run_op(8, 1'b1, 16'h0080, 16'h00FF, 1'b0);
    chk("t4_quo_const", o_quo, 16'h80);
    chk("t4_dvz_cleared", o_dvz, 0);
    run_op(8, 1'b0, 16'h0080, 16'h00FF, 1'b0);
    chk("t4u_rmd_const", o_rmd, 16'h80);
    run_op(8, 1'b0, 16'd200, 16'd7, 1'b1);
    run_op(8, 1'b1, 16'h0090, 16'h0005, 1'b1);

    sel16 = 1'b0;
    sgn_i = 1'b0; dvnd_i = 16'd250; dvsr_i = 16'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_ready", ready8, 1);
    chk("midrst_quo", quo8, 0);
    chk("midrst_rmd", rmd8, 0);
    chk("midrst_dvz", dvz8, 0);
    no_done = 1;
    for (c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done8 !== 1'b0) no_done = 0;
    end
    chk("midrst_no_done", no_done, 1);
    for (int i = 0; i < 2; i++) begin
      prev_q[i] = '0;
      prev_r[i] = '0;
    end
    run_op(8, 1'b0, 16'd100, 16'd9, 1'b0);
    chk("t5_quo_const", o_quo, 16'h0B);
    chk("t5_rmd_const", o_rmd, 16'h01);

    rand_ops(8, 30);
    rand_ops(16, 60);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
